// File: rtl/dw_accum_pkg.sv
// Shared types and default geometry for the depthwise accumulator and its PE array.
package dw_accum_pkg;
   localparam int DW_DEF  = 32;
   localparam int POX_DEF = 16;
   localparam int POY_DEF = 3;
   localparam int KK_DEF  = 9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      HOLD = 2'd2
   } state_t;
endpackage

// File: rtl/dw_accum_lane.sv
// Single-lane tap accumulator with bias add and post-op.
// Optional ReLU post-op is enabled by defining DW_ACCUM_RELU_EN.
module dw_accum_lane
   import dw_accum_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic          add,
   input  logic          fin,
   input  logic          clr,
   input  logic [DW-1:0] in_data,
   input  logic [DW-1:0] bias,
   output logic [DW-1:0] out_data
);
   logic [DW-1:0] acc;
   logic [DW-1:0] sum;
   logic [DW-1:0] post;

   // Plain modulo-2^DW arithmetic: overflow wraps, no saturation.
   assign sum = acc + in_data + bias;

`ifdef DW_ACCUM_RELU_EN
   assign post = sum[DW-1] ? '0 : sum;
`else
   assign post = sum;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc      <= '0;
         out_data <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (load) begin
         acc <= in_data;
      end else if (add) begin
         acc <= acc + in_data;
      end else if (fin) begin
         out_data <= post;
         acc      <= '0;
      end
   end
endmodule

// File: rtl/dw_accum.sv
// Depthwise output accumulator: sums KK taps per pixel over a POY x POX tile, adds bias.
// Build option DW_ACCUM_RELU_EN selects a ReLU post-op in every lane.
module dw_accum
   import dw_accum_pkg::*;
#(
   parameter int DW  = DW_DEF,
   parameter int POX = POX_DEF,
   parameter int POY = POY_DEF,
   parameter int KK  = KK_DEF
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [POY-1:0][POX-1:0][DW-1:0] in_data,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [DW-1:0]                  bias,
   input  logic                           flush,
   output logic [POY-1:0][POX-1:0][DW-1:0] out_data,
   output logic                           out_valid,
   input  logic                           out_ready
);
   localparam int CW = $clog2(KK);
   localparam logic [CW-1:0] LAST = CW'(KK - 1);

   state_t        state, state_nxt;
   logic [CW-1:0] tap_cnt, cnt_nxt;
   logic          xfer;
   logic          ld, ad, fn, cl;

   assign in_ready  = (state != HOLD);
   assign out_valid = (state == HOLD);
   assign xfer      = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         tap_cnt <= '0;
      end else begin
         state   <= state_nxt;
         tap_cnt <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = tap_cnt;
      ld = 1'b0;
      ad = 1'b0;
      fn = 1'b0;
      cl = 1'b0;
      case (state)
         IDLE: begin
            if (flush) begin
               cl      = 1'b1;
               cnt_nxt = '0;
            end else if (xfer) begin
               ld        = 1'b1;
               cnt_nxt   = CW'(1);
               state_nxt = ACC;
            end
         end
         ACC: begin
            if (flush) begin
               cl        = 1'b1;
               cnt_nxt   = '0;
               state_nxt = IDLE;
            end else if (xfer) begin
               if (tap_cnt == LAST) begin
                  fn        = 1'b1;
                  cnt_nxt   = '0;
                  state_nxt = HOLD;
               end else begin
                  ad      = 1'b1;
                  cnt_nxt = tap_cnt + CW'(1);
               end
            end
         end
         // Flush is deliberately ignored here so the finished tile is never lost.
         HOLD: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   for (genvar y = 0; y < POY; y++) begin : g_row
      for (genvar x = 0; x < POX; x++) begin : g_col
         dw_accum_lane #(.DW(DW)) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (ld),
            .add      (ad),
            .fin      (fn),
            .clr      (cl),
            .in_data  (in_data[y][x]),
            .bias     (bias),
            .out_data (out_data[y][x])
         );
      end
   end
endmodule

// File: tb/tb_dw_accum.sv
// Directed table-driven bench for dw_accum at default geometry (DW=32, 3x16 lanes, KK=9).
module tb_dw_accum;
   localparam int DW = 32, POX = 16, POY = 3, KK = 9;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [POY-1:0][POX-1:0][DW-1:0] in_data;
   logic in_valid, in_ready, flush, out_valid, out_ready;
   logic [DW-1:0] bias;
   logic [POY-1:0][POX-1:0][DW-1:0] out_data;

   int n_vec = 0;
   int n_err = 0;

   dw_accum #(.DW(DW), .POX(POX), .POY(POY), .KK(KK)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .bias      (bias),
      .flush     (flush),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] taps [9];
      logic [31:0] bias;
      logic [31:0] sp;        // tap value fed to lane [2][15] only
      logic [31:0] exp_plain;
      logic [31:0] exp_relu;
      logic [31:0] sp_plain;
      logic [31:0] sp_relu;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chk_data(string nm, logic [31:0] e, logic [31:0] esp);
      int by = -1, bx = -1;
      logic [31:0] ex, bg, be;
      n_vec++;
      for (int y = 0; y < POY; y++)
         for (int x = 0; x < POX; x++) begin
            ex = (y == 2 && x == 15) ? esp : e;
            if (out_data[y][x] !== ex && by < 0) begin
               by = y; bx = x; bg = out_data[y][x]; be = ex;
            end
         end
      if (by >= 0) begin
         n_err++;
         $display("FAIL %s lane[%0d][%0d] got %h want %h", nm, by, bx, bg, be);
      end
   endtask

   // Drives one tap; all lanes get v except lane [2][15] which gets sp.
   task automatic drive_tap(logic [31:0] v, logic [31:0] sp, logic [31:0] b);
      for (int y = 0; y < POY; y++)
         for (int x = 0; x < POX; x++)
            in_data[y][x] = (y == 2 && x == 15) ? sp : v;
      bias = b;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      bias = 32'h5A5A_5A5A;
   endtask

   // Nine equal taps; bias only meaningful on the last one.
   task automatic group(logic [31:0] v, logic [31:0] b);
      for (int t = 0; t < KK; t++)
         drive_tap(v, v, (t == KK-1) ? b : 32'h1234_5678);
   endtask

   function automatic logic [31:0] pick(logic [31:0] plain, logic [31:0] relu);
`ifdef DW_ACCUM_RELU_EN
      return relu;
`else
      return plain;
`endif
   endfunction

   initial begin
      for (int t = 0; t < 9; t++) begin
         vecs[0].taps[t] = 32'd1;
         vecs[1].taps[t] = 32'hFFFF_FFFB;            // -5
         vecs[2].taps[t] = 32'd3;
         vecs[3].taps[t] = (t < 2) ? 32'h7FFF_FFFF : 32'd0;
         vecs[4].taps[t] = 32'(t + 1);
      end
      vecs[0].bias = 32'd2;         vecs[0].sp = 32'd1;
      vecs[0].exp_plain = 32'd11;   vecs[0].exp_relu = 32'd11;
      vecs[0].sp_plain  = 32'd11;   vecs[0].sp_relu  = 32'd11;
      vecs[1].bias = 32'd0;         vecs[1].sp = 32'd2;
      vecs[1].exp_plain = 32'hFFFF_FFD3; vecs[1].exp_relu = 32'd0;
      vecs[1].sp_plain  = 32'd18;   vecs[1].sp_relu  = 32'd18;
      vecs[2].bias = 32'hFFFF_FFE2; vecs[2].sp = 32'd10;      // bias -30
      vecs[2].exp_plain = 32'hFFFF_FFFD; vecs[2].exp_relu = 32'd0;
      vecs[2].sp_plain  = 32'd60;   vecs[2].sp_relu  = 32'd60;
      vecs[3].bias = 32'd0;         vecs[3].sp = 32'h7FFF_FFFF;
      vecs[3].exp_plain = 32'hFFFF_FFFE; vecs[3].exp_relu = 32'd0;
      vecs[3].sp_plain  = 32'h7FFF_FFF7; vecs[3].sp_relu = 32'h7FFF_FFF7;
      vecs[4].bias = 32'd100;       vecs[4].sp = 32'hFFFF_FFFF;
      vecs[4].exp_plain = 32'd145;  vecs[4].exp_relu = 32'd145;
      vecs[4].sp_plain  = 32'd91;   vecs[4].sp_relu  = 32'd91;

      in_data = '0; in_valid = 1'b0; bias = '0; flush = 1'b0; out_ready = 1'b1;
      #12;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk_data("rst_out_data", 32'd0, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Table: nine taps, check latency, data, single-cycle valid.
      for (int i = 0; i < 5; i++) begin
         for (int t = 0; t < KK; t++) begin
            drive_tap(vecs[i].taps[t], vecs[i].sp, (t == KK-1) ? vecs[i].bias : 32'h5A5A_5A5A);
            if (t == KK-2) chk($sformatf("v%0d_early_valid", i), 32'(out_valid), 32'd0);
         end
         chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
         chk_data($sformatf("v%0d_data", i), pick(vecs[i].exp_plain, vecs[i].exp_relu),
                  pick(vecs[i].sp_plain, vecs[i].sp_relu));
         @(posedge clk); #1;
         chk($sformatf("v%0d_valid_drop", i), 32'(out_valid), 32'd0);
         chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
      end

      // Backpressure: HOLD keeps data, refuses taps.
      out_ready = 1'b0;
      group(32'd4, 32'd0);
      for (int c = 0; c < 4; c++) begin
         for (int y = 0; y < POY; y++)
            for (int x = 0; x < POX; x++) in_data[y][x] = 32'd1000;
         in_valid = 1'b1;
         @(posedge clk); #1;
         chk($sformatf("bp%0d_valid", c), 32'(out_valid), 32'd1);
         chk($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
         chk_data($sformatf("bp%0d_data", c), 32'd36, 32'd36);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release", 32'(out_valid), 32'd0);
      group(32'd2, 32'd1);
      chk_data("bp_next_group", 32'd19, 32'd19);
      @(posedge clk); #1;

      // Flush mid-group drops partial sum and the tap presented with it.
      for (int t = 0; t < 4; t++) drive_tap(32'd3, 32'd3, 32'd0);
      for (int y = 0; y < POY; y++)
         for (int x = 0; x < POX; x++) in_data[y][x] = 32'd50;
      in_valid = 1'b1; flush = 1'b1;
      chk("flush_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      group(32'd1, 32'd0);
      chk("flush_valid", 32'(out_valid), 32'd1);
      chk_data("flush_data", 32'd9, 32'd9);
      @(posedge clk); #1;

      // Flush during HOLD is ignored.
      out_ready = 1'b0;
      group(32'd7, 32'd0);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("hold_flush_valid", 32'(out_valid), 32'd1);
      chk_data("hold_flush_data", 32'd63, 32'd63);
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("hold_flush_drop", 32'(out_valid), 32'd0);

      // Reset while holding an output discards it immediately.
      out_ready = 1'b0;
      group(32'd6, 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("hold_rst_valid", 32'(out_valid), 32'd0);
      chk("hold_rst_in_ready", 32'(in_ready), 32'd1);
      chk_data("hold_rst_data", 32'd0, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b1;
      // Partial group then reset, then a clean group.
      for (int t = 0; t < 3; t++) drive_tap(32'd7, 32'd7, 32'd0);
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      group(32'd5, 32'd0);
      chk("post_rst_valid", 32'(out_valid), 32'd1);
      chk_data("post_rst_data", 32'd45, 32'd45);
      @(posedge clk); #1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
